vga_timing_gen: RTL

//   Produces the 640x480@60Hz VGA raster that every pixel-painting controller consumes.

---
 rtl/vga_timing_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster generator: divides clk to the pixel rate, scans hCount/vCount,
// and decodes sync, active-video and blanked colour combinationally from the counters.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_START = 144,
    parameter int H_END   = 783,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_START = 35,
    parameter int V_END   = 514
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic [11:0] vga_rgb
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] H_BEG_W  = 10'(H_START);
    localparam logic [9:0] H_FIN_W  = 10'(H_END);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] V_BEG_W  = 10'(V_START);
    localparam logic [9:0] V_FIN_W  = 10'(V_END);

    logic [3:0] r_div;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_pixel_tick;
    logic       r_frame_start;

    logic w_div_last;
    logic w_h_last;
    logic w_v_last;
    logic w_bright;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_h_last   = (r_h == H_LAST);
    assign w_v_last   = (r_v == V_LAST);

    // Counters step on the same edge that raises pixel_tick, so the tick marks the new position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= 4'd0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_pixel_tick  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_tick  <= w_div_last;
            r_frame_start <= w_div_last && w_h_last && w_v_last;
            if (w_div_last) begin
                r_div <= 4'd0;
                if (w_h_last) begin
                    r_h <= 10'd0;
                    r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    assign w_bright = (r_h >= H_BEG_W) && (r_h <= H_FIN_W) &&
                      (r_v >= V_BEG_W) && (r_v <= V_FIN_W);

    assign hCount      = r_h;
    assign vCount      = r_v;
    assign pixel_tick  = r_pixel_tick;
    assign frame_start = r_frame_start;
    assign hSync       = (r_h >= H_SYNC_W);
    assign vSync       = (r_v >= V_SYNC_W);
    assign bright      = w_bright;
    assign vga_rgb     = w_bright ? rgb_in : 12'h000;

endmodule
